// File: rtl/count_uart_reporter.sv
// UART status reporter: snapshots a 14-bit count and mode, then sends "DDDD M\r\n"
// as 8N1 frames, LSB first, with a baud divider and a serial double-dabble converter.
module count_uart_reporter #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        send,
   input  logic [13:0] count,
   input  logic        mode,
   output logic        tx,
   output logic        tx_busy,
   output logic        tx_done
);
   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_START, S_DATA, S_STOP} state_t;

   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [3:0]    conv_q;
   logic [2:0]    bit_q;
   logic [2:0]    byte_q;
   logic [13:0]   bin_q;
   logic [15:0]   bcd_q, bcd_adj, bcd_d;
   logic [6:0]    shreg_q;
   logic          ovf_q, mode_q;
   logic          tx_q, busy_q, done_q;
   logic [7:0]    msg_byte;

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_d = (bcd_adj << 1) | {15'd0, bin_q[13]};
   end

   always_comb begin
      msg_byte = 8'h0A;
      case (byte_q)
         3'd0:    msg_byte = ovf_q ? 8'h2D : {4'h3, bcd_q[15:12]};
         3'd1:    msg_byte = ovf_q ? 8'h2D : {4'h3, bcd_q[11:8]};
         3'd2:    msg_byte = ovf_q ? 8'h2D : {4'h3, bcd_q[7:4]};
         3'd3:    msg_byte = ovf_q ? 8'h2D : {4'h3, bcd_q[3:0]};
         3'd4:    msg_byte = 8'h20;
         3'd5:    msg_byte = mode_q ? 8'h44 : 8'h55;
         3'd6:    msg_byte = 8'h0D;
         default: msg_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         conv_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
         mode_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (send) begin
                  bin_q   <= count;
                  ovf_q   <= (count > 14'd9999);
                  mode_q  <= mode;
                  bcd_q   <= '0;
                  conv_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               bcd_q  <= bcd_d;
               bin_q  <= {bin_q[12:0], 1'b0};
               conv_q <= conv_q + 4'd1;
               if (conv_q == 4'd13) begin
                  tx_q    <= 1'b0;
                  baud_q  <= '0;
                  byte_q  <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q  <= '0;
                  tx_q    <= msg_byte[0];
                  shreg_q <= msg_byte[7:1];
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     tx_q    <= shreg_q[0];
                     shreg_q <= {1'b0, shreg_q[6:1]};
                     bit_q   <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (byte_q == 3'd7) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     byte_q  <= byte_q + 3'd1;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_count_uart_reporter.sv
// Bench for count_uart_reporter: table of messages plus hand sequences, with a
// mid-bit UART receiver popping expected bytes from a scoreboard queue.
module tb_count_uart_reporter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        send;
   logic [13:0] count;
   logic        mode;
   logic        tx, tx_busy, tx_done;

   always #5 clk = ~clk;

   count_uart_reporter #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
      .clk(clk), .reset(rst_n), .send(send), .count(count), .mode(mode),
      .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   logic [7:0]  sb_q[$];

   typedef struct {
      logic [13:0] c;
      logic        m;
      logic [63:0] msg;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [63:0] model_msg(input int unsigned c, input bit m);
      logic [31:0] digits;
      if (c > 9999) digits = "----";
      else digits = {8'(48 + c / 1000), 8'(48 + (c / 100) % 10),
                     8'(48 + (c / 10) % 10), 8'(48 + c % 10)};
      return {digits, 8'h20, (m ? 8'h44 : 8'h55), 8'h0D, 8'h0A};
   endfunction

   task automatic push_msg(input logic [63:0] msg);
      for (int b = 0; b < 8; b++) sb_q.push_back(msg[63 - 8*b -: 8]);
   endtask

   // Receiver: samples every negedge, takes mid-bit values, requires each bit flat for 10 cycles.
   bit         rx_active = 1'b0;
   int         rx_cyc = 0;
   logic       rx_ref = 1'b1;
   bit         rx_stable = 1'b1;
   logic [9:0] rx_sh = '0;
   logic       tx_prev = 1'b1;
   logic [7:0] rx_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_active = 1'b0;
      end else begin
         if (!rx_active && tx_prev === 1'b1 && tx === 1'b0) begin
            rx_active = 1'b1;
            rx_cyc    = 0;
            rx_stable = 1'b1;
         end
         if (rx_active) begin
            if (rx_cyc % 10 == 0) rx_ref = tx;
            else if (tx !== rx_ref) rx_stable = 1'b0;
            if (rx_cyc % 10 == 5) rx_sh = {tx, rx_sh[9:1]};
            rx_cyc++;
            if (rx_cyc == 100) begin
               rx_active = 1'b0;
               check(rx_stable && rx_sh[0] === 1'b0 && rx_sh[9] === 1'b1, "rx_frame",
                     {rx_stable, rx_sh[0], rx_sh[9]}, 3'b101);
               if (sb_q.size() == 0) begin
                  check(1'b0, "rx_unexpected_byte", rx_sh[8:1], 0);
               end else begin
                  rx_exp = sb_q.pop_front();
                  check(rx_sh[8:1] === rx_exp, "rx_byte", rx_sh[8:1], rx_exp);
               end
            end
         end
      end
      tx_prev = tx;
   end

   task automatic wait_start();
      int n = 0;
      while (tx !== 1'b0 && n < 25) begin
         @(negedge clk);
         send = 1'b0;
         n++;
      end
      check(tx === 1'b0 && n <= 20, "start_latency", n, 20);
   endtask

   task automatic launch(input logic [13:0] c, input logic m, input logic [63:0] msg);
      push_msg(msg);
      @(negedge clk);
      count = c;
      mode  = m;
      send  = 1'b1;
      wait_start();
   endtask

   task automatic finish_msg(input int poke_at, input bit scramble, input bit chain);
      int cyc = 0;
      bit busy_ok = 1'b1;
      while (tx_done !== 1'b1 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         send = (cyc == poke_at);
         if (scramble) begin
            count = 14'($urandom);
            mode  = 1'($urandom);
         end
         if (tx_done !== 1'b1 && tx_busy !== 1'b1) busy_ok = 1'b0;
      end
      check(cyc == 800, "msg_length", cyc, 800);
      check(busy_ok, "busy_high", busy_ok, 1);
      check(tx_busy === 1'b0 && tx_done === 1'b1, "done_edge", {tx_busy, tx_done}, 1);
      if (chain) begin
         push_msg(model_msg(5, 1'b0));
         count = 14'd5;
         mode  = 1'b0;
         send  = 1'b1;
      end else begin
         @(negedge clk);
         check(tx_done === 1'b0, "done_width", tx_done, 0);
      end
   endtask

   task automatic idle_check(input int cycles);
      bit ok = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
      end
      check(ok, "idle_after", ok, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      tbl[0] = '{14'd1234,  1'b0, {"1234 U", 8'h0D, 8'h0A}};
      tbl[1] = '{14'd9999,  1'b1, {"9999 D", 8'h0D, 8'h0A}};
      tbl[2] = '{14'd0,     1'b0, {"0000 U", 8'h0D, 8'h0A}};
      tbl[3] = '{14'd10000, 1'b0, {"---- U", 8'h0D, 8'h0A}};
      tbl[4] = '{14'd16383, 1'b1, {"---- D", 8'h0D, 8'h0A}};

      rst_n = 1'b0;
      send  = 1'b0;
      count = '0;
      mode  = 1'b0;
      repeat (3) @(negedge clk);
      check(tx === 1'b1, "reset_tx", tx, 1);
      check(tx_busy === 1'b0, "reset_busy", tx_busy, 0);
      check(tx_done === 1'b0, "reset_done", tx_done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         launch(tbl[i].c, tbl[i].m, tbl[i].msg);
         finish_msg(0, 1'b0, 1'b0);
         idle_check(20);
      end

      // Snapshot stability with a second request mid-message
      launch(14'd42, 1'b0, model_msg(42, 1'b0));
      finish_msg(300, 1'b1, 1'b0);
      idle_check(40);

      // Back-to-back: request in the tx_done cycle
      launch(14'd77, 1'b1, model_msg(77, 1'b1));
      finish_msg(0, 1'b0, 1'b1);
      wait_start();
      finish_msg(0, 1'b0, 1'b0);
      idle_check(20);

      // Reset during byte 2 data bit d2 (0x33 -> d2 = 0)
      launch(14'd1234, 1'b0, model_msg(1234, 1'b0));
      repeat (235) @(negedge clk);
      check(tx === 1'b0, "pre_reset_tx", tx, 0);
      rst_n = 1'b0;
      #1;
      check(tx === 1'b1, "async_reset_tx", tx, 1);
      check(tx_busy === 1'b0, "async_reset_busy", tx_busy, 0);
      check(tx_done === 1'b0, "async_reset_done", tx_done, 0);
      sb_q.delete();
      ok = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
      end
      check(ok, "reset_hold", ok, 1);
      rst_n = 1'b1;
      idle_check(30);
      launch(14'd8, 1'b0, model_msg(8, 1'b0));
      finish_msg(0, 1'b0, 1'b0);
      idle_check(20);

      check(sb_q.size() == 0, "sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/count_uart_reporter.md
Name: count_uart_reporter

Overview:
- UART transmit-side status reporter for the up/down counter subsystem. It is the outbound path alongside the command receiver that delivers 'm'/'r'/'s'/'c' bytes.
- On a one-cycle `send` request it snapshots the 14-bit count and the mode bit. It converts the count to four ASCII decimal digits and serialises the fixed 8-byte message "DDDD M\r\n" on `tx` as 8N1, LSB first.
- It contains its own baud divider, binary-to-BCD converter, message sequencer and bit serialiser.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate. BAUD_DIV = CLK_FREQ / BAUD_RATE (integer, truncated), which is the number of clk cycles per bit. The requirement is BAUD_DIV >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- send, input, 1: report request, one-cycle pulse.
- count, input, 14: counter value, unsigned.
- mode, input, 1: 0 = up, 1 = down.
- tx, output, 1: UART serial line, idles high.
- tx_busy, output, 1: high from request acceptance until the end of the final stop bit.
- tx_done, output, 1: one-cycle pulse when the message is complete.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While reset = 0: tx = 1, tx_busy = 0, tx_done = 0, FSM = IDLE, all counters and snapshot registers = 0. Release of reset is synchronous to clk.
- Request acceptance:
  - `send` is sampled only in IDLE. The first cycle `send` = 1 in IDLE latches count and mode and sets tx_busy = 1 on the following edge.
  - `send` while tx_busy = 1 is ignored. There is no queue and no latching.
  - `send` held high for multiple cycles in IDLE starts exactly one message.
- FSM states: IDLE -> CONVERT -> START -> DATA -> STOP -> (next byte: START | last byte: DONE) -> IDLE.
- CONVERT:
  - Binary-to-BCD conversion of the latched count, by double-dabble or repeated subtraction; multicycle is allowed.
  - It must finish within 16 cycles. The start bit (tx falling) must occur no more than 20 clk cycles after the `send` cycle.
  - Latched count > 9999: all four digit characters are '-' (0x2D).
  - Leading zeros are transmitted, e.g. 7 -> "0007".
- Message bytes, in order:
  - bytes 0–3: thousands, hundreds, tens, units, each 0x30 + digit;
  - byte 4: 0x20 (space);
  - byte 5: 'U' (0x55) if latched mode = 0, 'D' (0x44) if 1;
  - byte 6: 0x0D;
  - byte 7: 0x0A.
- Frame timing:
  - Each byte is start bit (0), data[0]..data[7], stop bit (1); every bit is held exactly BAUD_DIV cycles.
  - The baud counter is cleared on entry to each START, so bit lengths have no accumulated error.
  - Bytes are sent back to back with no idle gap: the next start bit follows the previous stop bit immediately.
  - Total message = 80 × BAUD_DIV cycles from the first start-bit edge to the end of the last stop bit.
- Completion:
  - tx_done = 1 for exactly one cycle on the cycle after the last stop bit period ends.
  - tx_busy falls on that same edge, and the FSM returns to IDLE.
  - A `send` in the tx_done cycle is accepted.
- Snapshot: changes on count/mode after acceptance do not affect the message in flight.
- Reset mid-message: tx is forced high immediately (asynchronously) and the message is abandoned. After release the block is in IDLE and no partial message resumes.
- tx is registered, so it never glitches between bit boundaries.

Test Plan:
Use CLK_FREQ = 1000 and BAUD_RATE = 100 (BAUD_DIV = 10) for all benches.
- Basic message: count = 1234, mode = 0, one `send` pulse -> tx bytes 0x31 0x32 0x33 0x34 0x20 0x55 0x0D 0x0A, each 10-cycle bits LSB first; tx_busy high throughout; tx_done pulses once 800 cycles after the first start bit.
- Wrap and zero boundaries: count = 9999 with mode = 1 -> "9999 D\r\n"; count = 0 -> "0000 U\r\n"; count = 10000 -> "---- U\r\n".
- Snapshot stability: count = 42 at `send`, then count changes every cycle -> the message is "0042 ..." unchanged. A second `send` mid-message is ignored, giving exactly one tx_done.
- Back-to-back: assert `send` in the tx_done cycle with count = 5 -> the second message "0005 U\r\n" starts within 20 cycles; both are decoded correctly.
- Reset mid-message: assert reset = 0 during byte 2's data bits -> tx = 1 in the same cycle, tx_busy = 0, no tx_done. After release, `send` with count = 8 -> a clean "0008 U\r\n".
- Bit timing check: a bench UART receiver sampling at mid-bit measures every bit width = 10 cycles ±0 and start latency ≤ 20 cycles.
